// File: rtl/p_dmem_responder.sv
// Word-addressed data memory answering single load/store requests over valid/ready
// channels, with a fixed number of wait states before each response.
module p_dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic              accept, wait_done, rsp_hs, addr_err;
  logic [ADDR_W-1:0] word_idx;

  assign accept    = req_valid_i && ready_q;
  assign wait_done = (state_q == WAIT) && (cnt_q == 4'd0);
  assign rsp_hs    = (state_q == RESP) && rsp_ready_i;
  assign addr_err  = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT);
  assign word_idx  = addr_q[ADDR_W+1:2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = WAIT;
        cnt_d   = 4'(WAIT_CYCLES);
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Ready is registered so it stays low through reset and rises one edge after release.
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    req_ready_o = ready_q;
    rsp_valid_o = (state_q == RESP);
    rsp_rdata_o = rdata_q;
    rsp_err_o   = err_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
      if (wait_done) begin
        err_q   <= addr_err;
        rdata_q <= (addr_err || we_q) ? 32'd0 : mem[word_idx];
      end else if (rsp_hs) begin
        err_q   <= 1'b0;
        rdata_q <= 32'd0;
      end
    end
  end

  // RAM has no reset; a store commits only on the WAIT exit edge.
  always_ff @(posedge clk_i) begin
    if (wait_done && we_q && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[word_idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule
